main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm.sv | 189 ++++++++++++++++++
 tb/tb_main_control_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Purpose : multicycle-CPU main control; Moore FSM that sequences fetch/decode/execute per opcode.
// Latency : FETCH->FETCH with mem_ready=1: lw 5, sw/R-type/nandi 4, jump 3 cycles.
// Backpr. : FETCH, MEMRD and MEMWR hold while mem_ready=0; ILLEGAL holds until reset.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   opcode[5:0]        instruction[31:26], captured in DECODE
//   mem_ready          memory access completes in the cycle it is high
//   PCWrite..ALUSrcA   1-bit datapath controls; ALUSrcB/PCSource/ALU_Op 2-bit selects
//   state[3:0]         current state code
//   illegal            sticky illegal-opcode flag
//   instr_count[15:0]  retired-instruction counter (wraps)
module main_control_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_NANDI = 6'b001100,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        MemtoReg,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic [1:0]  ALU_Op,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [15:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_ALU_WB   = 4'd7,
      S_NANDI_EX = 4'd8,
      S_JUMP     = 4'd9,
      S_ILLEGAL  = 4'd10
   } st_t;

   st_t         cur_st;
   logic [5:0]  op_q;
   logic        illegal_q;
   logic [15:0] count_q;

   assign state       = cur_st;
   assign illegal     = illegal_q;
   assign instr_count = count_q;

   // State, latched opcode, sticky flag and retirement counter.
   // Every transition back to FETCH from an execute/writeback state retires one instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_st    <= S_FETCH;
         op_q      <= 6'd0;
         illegal_q <= 1'b0;
         count_q   <= 16'd0;
      end else begin
         case (cur_st)
            S_FETCH: begin
               if (mem_ready) cur_st <= S_DECODE;
            end
            S_DECODE: begin
               op_q <= opcode;
               case (opcode)
                  OP_LW, OP_SW: cur_st <= S_MEMADR;
                  OP_RTYPE:     cur_st <= S_RTYPE_EX;
                  OP_NANDI:     cur_st <= S_NANDI_EX;
                  OP_J:         cur_st <= S_JUMP;
                  default: begin
                     cur_st    <= S_ILLEGAL;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            S_MEMADR: begin
               // Live opcode may already belong to the next fetch; use the latched copy.
               cur_st <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               if (mem_ready) cur_st <= S_MEMWB;
            end
            S_MEMWB: begin
               cur_st  <= S_FETCH;
               count_q <= count_q + 16'd1;
            end
            S_MEMWR: begin
               if (mem_ready) begin
                  cur_st  <= S_FETCH;
                  count_q <= count_q + 16'd1;
               end
            end
            S_RTYPE_EX, S_NANDI_EX: begin
               cur_st <= S_ALU_WB;
            end
            S_ALU_WB, S_JUMP: begin
               cur_st  <= S_FETCH;
               count_q <= count_q + 16'd1;
            end
            S_ILLEGAL: begin
               cur_st    <= S_ILLEGAL;
               illegal_q <= 1'b1;
            end
            default: begin
               // Unused codes 11-15 recover to FETCH.
               cur_st <= S_FETCH;
            end
         endcase
      end
   end

   // Moore decode of the current state; only FETCH's PCWrite looks at mem_ready.
   always_comb begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      MemtoReg = 1'b0;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      PCSource = 2'b00;
      ALU_Op   = 2'b00;
      case (cur_st)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            ALUSrcB = 2'b01;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_RTYPE_EX: begin
            ALUSrcA = 1'b1;
            ALU_Op  = 2'b10;
         end
         S_NANDI_EX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALU_Op  = 2'b01;
         end
         S_ALU_WB: begin
            RegWrite = 1'b1;
            RegDst   = (op_q == OP_RTYPE);
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            ALU_Op   = 2'b11;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_main_control_fsm.sv
// Purpose : checks main_control_fsm against an instruction-plan model, directed and random.
// Latency : model advances once per clock, compared on the falling edge.
// Backpr. : mem_ready is randomised; the model holds wait states while it is low.
module tb_main_control_fsm;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_NANDI = 6'b001100;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opcode = 6'd0;
   logic        mem_ready = 1'b0;
   logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, PCSource, ALU_Op;
   logic [3:0]  state;
   logic        illegal;
   logic [15:0] instr_count;
   logic [14:0] ctrl_vec;

   always #5 clk = ~clk;

   main_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_Op(ALU_Op),
      .state(state), .illegal(illegal), .instr_count(instr_count)
   );

   assign ctrl_vec = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                      RegWrite, ALUSrcA, ALUSrcB, PCSource, ALU_Op};

   int n_vec = 0;
   int n_bad = 0;

   // Model: current state code, remaining steps of the decoded instruction, counter, flag.
   int          m_st = 0;
   int          m_plan[$];
   logic [15:0] m_cnt = 16'd0;
   logic        m_ill = 1'b0;
   logic [5:0]  m_lat = 6'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Control outputs each state must show, straight from the state table.
   function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic [5:0] lat);
      logic pw, iord, mrd, mwr, irw, m2r, rd, rw, asa;
      logic [1:0] asb, pcs, aop;
      {pw, iord, mrd, mwr, irw, m2r, rd, rw, asa} = 9'd0;
      asb = 2'b00; pcs = 2'b00; aop = 2'b00;
      case (st)
         0:  begin mrd = 1; irw = 1; asb = 2'b01; pw = mr; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rd = (lat == OP_RTYPE); end
         8:  begin asa = 1; asb = 2'b10; aop = 2'b01; end
         9:  begin pw = 1; pcs = 2'b10; aop = 2'b11; end
         default: ;
      endcase
      return {pw, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, pcs, aop};
   endfunction

   // One clock of the model: decode builds a list of steps; exhausting it retires.
   task automatic model_step(input logic r, input logic [5:0] op, input logic mr);
      if (r) begin
         m_st = 0; m_cnt = 16'd0; m_ill = 1'b0; m_lat = 6'd0;
         m_plan.delete();
      end else if (m_st == 10) begin
         m_st = 10;
      end else if ((m_st == 0 || m_st == 3 || m_st == 5) && !mr) begin
         m_st = m_st;
      end else if (m_st == 0) begin
         m_st = 1;
      end else if (m_st == 1) begin
         m_lat = op;
         m_plan.delete();
         if (op == OP_LW) begin m_plan.push_back(2); m_plan.push_back(3); m_plan.push_back(4); end
         else if (op == OP_SW) begin m_plan.push_back(2); m_plan.push_back(5); end
         else if (op == OP_RTYPE) begin m_plan.push_back(6); m_plan.push_back(7); end
         else if (op == OP_NANDI) begin m_plan.push_back(8); m_plan.push_back(7); end
         else if (op == OP_J) m_plan.push_back(9);
         else begin m_plan.push_back(10); m_ill = 1'b1; end
         m_st = m_plan.pop_front();
      end else if (m_plan.size() == 0) begin
         m_st = 0;
         m_cnt = m_cnt + 16'd1;
      end else begin
         m_st = m_plan.pop_front();
      end
   endtask

   // Drive one cycle's inputs after the rising edge, compare at the falling edge, advance model.
   task automatic cyc(input logic r, input logic [5:0] op, input logic mr);
      @(posedge clk);
      #1;
      reset = r; opcode = op; mem_ready = mr;
      @(negedge clk);
      chk("state", 32'(state), 32'(m_st));
      chk("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(m_st, mr, m_lat)));
      chk("illegal", 32'(illegal), 32'(m_ill));
      chk("instr_count", 32'(instr_count), 32'(m_cnt));
      model_step(r, op, mr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lw_seq[6] = '{0, 1, 2, 3, 4, 0};
      logic [5:0] ops[5] = '{OP_RTYPE, OP_LW, OP_SW, OP_NANDI, OP_J};
      int ill_run = 0;

      repeat (2) @(posedge clk);
      model_step(1'b1, 6'd0, 1'b1);

      // Reset held: FETCH decode visible.
      cyc(1'b1, 6'd0, 1'b1);
      chk("rst_state", 32'(state), 0);
      chk("rst_fetch_ctrl", 32'({MemRead, IRWrite, ALUSrcB}), 32'b1101);
      chk("rst_count", 32'(instr_count), 0);

      // Load with no stalls.
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, OP_LW, 1'b1);
         chk("lw_seq", 32'(state), 32'(lw_seq[i]));
         if (i == 4) chk("lw_wb", 32'({MemtoReg, RegWrite}), 32'b11);
      end
      chk("lw_count", 32'(instr_count), 1);

      // R-type then nandi.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, OP_RTYPE, 1'b1);
         if (i == 1) chk("r_aluop", 32'({state, ALU_Op}), 32'({4'd6, 2'b10}));
         if (i == 2) chk("r_regdst", 32'({state, RegDst}), 32'({4'd7, 1'b1}));
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, OP_NANDI, 1'b1);
         if (i == 1) chk("nandi_aluop", 32'({state, ALU_Op}), 32'({4'd8, 2'b01}));
         if (i == 2) chk("nandi_regdst", 32'({state, RegDst}), 32'({4'd7, 1'b0}));
      end
      chk("alu_count", 32'(instr_count), 3);

      // Reset during a MEMRD stall.
      cyc(1'b0, OP_LW, 1'b1);
      cyc(1'b0, OP_LW, 1'b0);
      cyc(1'b0, OP_LW, 1'b0);
      cyc(1'b0, OP_LW, 1'b0);
      cyc(1'b1, OP_LW, 1'b0);
      chk("memrd_stall", 32'(state), 3);
      cyc(1'b0, OP_LW, 1'b1);
      chk("stall_rst", 32'({state, instr_count, RegWrite}), 32'({4'd0, 16'd0, 1'b0}));

      // Store with three wait cycles.
      cyc(1'b0, OP_SW, 1'b1);
      cyc(1'b0, OP_SW, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, OP_SW, (i == 3));
         chk("sw_hold", 32'({state, MemWrite}), 32'({4'd5, 1'b1}));
      end
      cyc(1'b0, OP_SW, 1'b1);
      chk("sw_count", 32'({state, instr_count}), 32'({4'd0, 16'd1}));

      // Illegal opcode sticks until reset.
      cyc(1'b0, 6'h3f, 1'b1);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 6'h3f, 1'($urandom));
         chk("ill_hold", 32'({state, illegal, ctrl_vec}), 32'({4'd10, 1'b1, 15'd0}));
      end
      cyc(1'b1, 6'h3f, 1'b0);
      cyc(1'b0, OP_J, 1'b0);
      chk("ill_clear", 32'({state, illegal}), 32'({4'd0, 1'b0}));

      // Counter wrap on a jump retirement.
      force dut.count_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      cyc(1'b0, OP_J, 1'b1);
      release dut.count_q;
      cyc(1'b0, OP_J, 1'b1);
      cyc(1'b0, OP_J, 1'b1);
      chk("jump_ctrl", 32'({state, PCWrite, PCSource}), 32'({4'd9, 1'b1, 2'b10}));
      cyc(1'b0, OP_J, 1'b1);
      chk("wrap_count", 32'({state, instr_count}), 32'({4'd0, 16'd0}));

      // Random traffic: opcode changes every cycle, mem_ready stalls, sporadic resets.
      for (int i = 0; i < 3000; i++) begin
         logic r;
         logic [5:0] op;
         ill_run = (m_st == 10) ? ill_run + 1 : 0;
         r  = ($urandom_range(0, 199) == 0) || (ill_run > 12);
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 4)];
         cyc(r, op, ($urandom_range(0, 3) != 0));
         if (MemRead && MemWrite) chk("rd_wr_excl", 32'({MemRead, MemWrite}), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
